ss_map_sensor: RTL and testbench

- Collision/terrain sensor for the player sprite.
- Sits directly upstream of the map muxer: drives its worldmap_addr port and consumes the worldmap_data it returns.
- On each start pulse it reads the tile under the player, then the 4 orthogonal neighbours, and publishes registered solid/hazard/goal flags.
- The movement/physics logic uses these flags to gate LocX/LocY updates.

---
 rtl/ss_map_pkg.sv | 90 +++++++++
 rtl/ss_map_sensor_if.sv | 34 +++
 rtl/ss_probe_pipe.sv | 35 +++
 rtl/ss_map_sensor.sv | 199 +++++++++++++++++++
 tb/tb_ss_map_sensor.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/ss_map_pkg.sv
// Shared types and helpers for the player map sensor.
// Build option SS_SENSOR_DIAG_EN adds four diagonal probes to each sweep.
package ss_map_pkg;

    localparam int unsigned MAP_LOG2 = 7;
    localparam int unsigned ADDR_W   = 2 * MAP_LOG2;

    typedef logic [MAP_LOG2-1:0] coord_t;
    localparam coord_t COORD_MAX = '1;

    typedef enum logic [1:0] {
        OPEN   = 2'b00,
        SOLID  = 2'b01,
        HAZARD = 2'b10,
        GOAL   = 2'b11
    } tile_t;

    typedef enum logic [3:0] {
        P_CENTER,
        P_LEFT,
        P_RIGHT,
        P_UP,
        P_DOWN,
        P_UL,
        P_UR,
        P_DL,
        P_DR
    } probe_e;

`ifdef SS_SENSOR_DIAG_EN
    localparam probe_e      LAST_PROBE = P_DR;
    localparam int unsigned NUM_NBR    = 8;
`else
    localparam probe_e      LAST_PROBE = P_DOWN;
    localparam int unsigned NUM_NBR    = 4;
`endif

    // Travels alongside each read so returning data can be attributed to its probe.
    typedef struct packed {
        logic   valid;
        probe_e probe;
        logic   skip;
    } tag_t;

    function automatic logic [ADDR_W-1:0] map_addr(input coord_t x, input coord_t y);
        return {y, x};
    endfunction

    // A probe is skipped when its tile lies off the map or the player itself is off the map.
    function automatic logic probe_skip(input probe_e p, input coord_t x, input coord_t y,
                                        input logic oom);
        logic xl, xr, yu, yd, edge_hit;
        xl = (x == '0);
        xr = (x == COORD_MAX);
        yu = (y == '0);
        yd = (y == COORD_MAX);
        case (p)
            P_LEFT:  edge_hit = xl;
            P_RIGHT: edge_hit = xr;
            P_UP:    edge_hit = yu;
            P_DOWN:  edge_hit = yd;
            P_UL:    edge_hit = xl | yu;
            P_UR:    edge_hit = xr | yu;
            P_DL:    edge_hit = xl | yd;
            P_DR:    edge_hit = xr | yd;
            default: edge_hit = 1'b0;
        endcase
        return oom | edge_hit;
    endfunction

    function automatic logic [ADDR_W-1:0] probe_addr(input probe_e p, input coord_t x,
                                                     input coord_t y);
        coord_t px, py;
        px = x;
        py = y;
        case (p)
            P_LEFT:  px = x - coord_t'(1);
            P_RIGHT: px = x + coord_t'(1);
            P_UP:    py = y - coord_t'(1);
            P_DOWN:  py = y + coord_t'(1);
            P_UL: begin px = x - coord_t'(1); py = y - coord_t'(1); end
            P_UR: begin px = x + coord_t'(1); py = y - coord_t'(1); end
            P_DL: begin px = x - coord_t'(1); py = y + coord_t'(1); end
            P_DR: begin px = x + coord_t'(1); py = y + coord_t'(1); end
            default: ;
        endcase
        return map_addr(px, py);
    endfunction

endpackage

// File: rtl/ss_map_sensor_if.sv
// Sensor request/result and world-map read port bundle.
// slave: the sensor; master: the requester plus map muxer side.
interface ss_map_sensor_if;
    import ss_map_pkg::*;

    logic                start;
    logic [7:0]          loc_x;
    logic [7:0]          loc_y;
    logic [ADDR_W-1:0]   worldmap_addr;
    logic [1:0]          worldmap_data;
    logic                busy;
    logic                sensor_valid;
    logic                solid_left;
    logic                solid_right;
    logic                solid_up;
    logic                solid_down;
    logic                on_hazard;
    logic                on_goal;
    logic                out_of_map;
    logic [3:0]          diag_solid;

    modport slave (
        input  start, loc_x, loc_y, worldmap_data,
        output worldmap_addr, busy, sensor_valid, solid_left, solid_right, solid_up,
               solid_down, on_hazard, on_goal, out_of_map, diag_solid
    );

    modport master (
        output start, loc_x, loc_y, worldmap_data,
        input  worldmap_addr, busy, sensor_valid, solid_left, solid_right, solid_up,
               solid_down, on_hazard, on_goal, out_of_map, diag_solid
    );

endinterface

// File: rtl/ss_probe_pipe.sv
// Delays probe tags by the map read latency so each tag meets its worldmap_data.
module ss_probe_pipe
    import ss_map_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic clk_75,
    input  logic reset,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t pipe_q [0:RD_LATENCY-1];
    tag_t pipe_d [0:RD_LATENCY-1];

    always_comb begin
        pipe_d[0] = tag_i;
        for (int i = 1; i < int'(RD_LATENCY); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_75 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tag_o = pipe_q[RD_LATENCY-1];

endmodule

// File: rtl/ss_map_sensor.sv
// Player collision/terrain sensor: sweeps the tile under the player and its neighbours.
// Build option SS_SENSOR_DIAG_EN adds ul/ur/dl/dr probes and populates diag_solid.
module ss_map_sensor
    import ss_map_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic            clk_75,
    input  logic            reset,
    ss_map_sensor_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    localparam logic [1:0] DrainLast = 2'(RD_LATENCY - 1);

    state_e              state_q, state_d;
    probe_e              probe_q, probe_d;
    probe_e              probe_nxt;
    logic [1:0]          drain_q, drain_d;
    coord_t              x_q, x_d, y_q, y_d;
    logic                oom_q, oom_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    // Working results fill in as reads return; published only on the DONE transition.
    logic [NUM_NBR-1:0]  wk_solid_q, wk_solid_d;
    logic                wk_haz_q, wk_haz_d;
    logic                wk_goal_q, wk_goal_d;
    logic [3:0]          pub_solid_q, pub_solid_d;
    logic                pub_haz_q, pub_haz_d;
    logic                pub_goal_q, pub_goal_d;
    logic                pub_oom_q, pub_oom_d;
`ifdef SS_SENSOR_DIAG_EN
    logic [3:0]          pub_diag_q, pub_diag_d;
`endif

    tag_t                tag_in, tag_out;
    tile_t               code;
    logic                nbr_solid;

    always_comb begin
        tag_in       = '0;
        tag_in.valid = (state_q == StIssue);
        tag_in.probe = probe_q;
        tag_in.skip  = probe_skip(probe_q, x_q, y_q, oom_q);
    end

    ss_probe_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_probe_pipe (
        .clk_75 (clk_75),
        .reset  (reset),
        .tag_i  (tag_in),
        .tag_o  (tag_out)
    );

    always_comb begin
        state_d     = state_q;
        probe_d     = probe_q;
        drain_d     = drain_q;
        x_d         = x_q;
        y_d         = y_q;
        oom_d       = oom_q;
        addr_d      = addr_q;
        wk_solid_d  = wk_solid_q;
        wk_haz_d    = wk_haz_q;
        wk_goal_d   = wk_goal_q;
        pub_solid_d = pub_solid_q;
        pub_haz_d   = pub_haz_q;
        pub_goal_d  = pub_goal_q;
        pub_oom_d   = pub_oom_q;
`ifdef SS_SENSOR_DIAG_EN
        pub_diag_d  = pub_diag_q;
`endif
        probe_nxt   = probe_e'(probe_q + 4'd1);
        code        = tile_t'(bus.worldmap_data);
        nbr_solid   = tag_out.skip || (code == SOLID);

        if (tag_out.valid) begin
            case (tag_out.probe)
                P_CENTER: begin
                    wk_haz_d  = !tag_out.skip && (code == HAZARD);
                    wk_goal_d = !tag_out.skip && (code == GOAL);
                end
                P_LEFT:  wk_solid_d[0] = nbr_solid;
                P_RIGHT: wk_solid_d[1] = nbr_solid;
                P_UP:    wk_solid_d[2] = nbr_solid;
                P_DOWN:  wk_solid_d[3] = nbr_solid;
`ifdef SS_SENSOR_DIAG_EN
                P_UL:    wk_solid_d[4] = nbr_solid;
                P_UR:    wk_solid_d[5] = nbr_solid;
                P_DL:    wk_solid_d[6] = nbr_solid;
                P_DR:    wk_solid_d[7] = nbr_solid;
`endif
                default: ;
            endcase
        end

        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start) begin
                    x_d     = bus.loc_x[MAP_LOG2-1:0];
                    y_d     = bus.loc_y[MAP_LOG2-1:0];
                    oom_d   = (|bus.loc_x[7:MAP_LOG2]) | (|bus.loc_y[7:MAP_LOG2]);
                    probe_d = P_CENTER;
                    if (!oom_d) begin
                        addr_d = map_addr(x_d, y_d);
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (probe_q == LAST_PROBE) begin
                    drain_d = '0;
                    state_d = StDrain;
                end else begin
                    probe_d = probe_nxt;
                    // Skipped slots leave the address bus untouched.
                    if (!probe_skip(probe_nxt, x_q, y_q, oom_q)) begin
                        addr_d = probe_addr(probe_nxt, x_q, y_q);
                    end
                end
            end
            StDrain: begin
                if (drain_q == DrainLast) begin
                    state_d     = StDone;
                    pub_solid_d = wk_solid_d[3:0];
                    pub_haz_d   = wk_haz_d;
                    pub_goal_d  = wk_goal_d;
                    pub_oom_d   = oom_q;
`ifdef SS_SENSOR_DIAG_EN
                    pub_diag_d  = {wk_solid_d[4], wk_solid_d[5], wk_solid_d[6], wk_solid_d[7]};
`endif
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_75 or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            probe_q     <= P_CENTER;
            drain_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            oom_q       <= 1'b0;
            addr_q      <= '0;
            wk_solid_q  <= '0;
            wk_haz_q    <= 1'b0;
            wk_goal_q   <= 1'b0;
            pub_solid_q <= '0;
            pub_haz_q   <= 1'b0;
            pub_goal_q  <= 1'b0;
            pub_oom_q   <= 1'b0;
`ifdef SS_SENSOR_DIAG_EN
            pub_diag_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            probe_q     <= probe_d;
            drain_q     <= drain_d;
            x_q         <= x_d;
            y_q         <= y_d;
            oom_q       <= oom_d;
            addr_q      <= addr_d;
            wk_solid_q  <= wk_solid_d;
            wk_haz_q    <= wk_haz_d;
            wk_goal_q   <= wk_goal_d;
            pub_solid_q <= pub_solid_d;
            pub_haz_q   <= pub_haz_d;
            pub_goal_q  <= pub_goal_d;
            pub_oom_q   <= pub_oom_d;
`ifdef SS_SENSOR_DIAG_EN
            pub_diag_q  <= pub_diag_d;
`endif
        end
    end

    assign bus.worldmap_addr = addr_q;
    assign bus.busy          = (state_q == StIssue) || (state_q == StDrain);
    assign bus.sensor_valid  = (state_q == StDone);
    assign bus.solid_left    = pub_solid_q[0];
    assign bus.solid_right   = pub_solid_q[1];
    assign bus.solid_up      = pub_solid_q[2];
    assign bus.solid_down    = pub_solid_q[3];
    assign bus.on_hazard     = pub_haz_q;
    assign bus.on_goal       = pub_goal_q;
    assign bus.out_of_map    = pub_oom_q;
`ifdef SS_SENSOR_DIAG_EN
    assign bus.diag_solid    = pub_diag_q;
`else
    assign bus.diag_solid    = 4'b0000;
`endif

endmodule

// File: tb/tb_ss_map_sensor.sv
// Directed bench: one sensor at read latency 1 and one at latency 3 share stimulus.
module tb_ss_map_sensor;
    import ss_map_pkg::*;

    typedef struct {
        logic [7:0] x, y;
        logic [1:0] c, l, r, u, d;
        logic [3:0] solid;            // {left, right, up, down}
        logic       haz, goal, oom;
    } vec_t;

    logic        clk_75 = 1'b0;
    logic        reset  = 1'b0;
    logic        start  = 1'b0;
    logic [7:0]  loc_x  = '0;
    logic [7:0]  loc_y  = '0;
    logic [1:0]  map_mem [0:16383];
    logic [1:0]  rd0_q;
    logic [2:0][1:0] rd1_q;

    int          total = 0;
    int          bad   = 0;
    logic [19:0] vmask [2];
    logic [19:0] bmask [2];
    logic [6:0]  f_tr  [2][20];
    logic [3:0]  g_tr  [2][20];
    logic [13:0] a_tr  [2][20];
    logic [13:0] last_addr [2];
    vec_t        vecs [8];

    always #5 clk_75 = ~clk_75;

    ss_map_sensor_if if0 ();
    ss_map_sensor_if if1 ();

    assign if0.start = start;
    assign if0.loc_x = loc_x;
    assign if0.loc_y = loc_y;
    assign if1.start = start;
    assign if1.loc_x = loc_x;
    assign if1.loc_y = loc_y;
    assign if0.worldmap_data = rd0_q;
    assign if1.worldmap_data = rd1_q[2];

    // Map RAM models: latency 1 for dut0, latency 3 for dut1.
    always @(posedge clk_75) begin
        rd0_q <= map_mem[if0.worldmap_addr];
        rd1_q <= {rd1_q[1:0], map_mem[if1.worldmap_addr]};
    end

    ss_map_sensor #(.RD_LATENCY(1)) u_dut0 (.clk_75(clk_75), .reset(reset), .bus(if0));
    ss_map_sensor #(.RD_LATENCY(3)) u_dut1 (.clk_75(clk_75), .reset(reset), .bus(if1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sample(input int c);
        vmask[0][c] = if0.sensor_valid;
        bmask[0][c] = if0.busy;
        f_tr[0][c]  = {if0.out_of_map, if0.on_goal, if0.on_hazard, if0.solid_left,
                       if0.solid_right, if0.solid_up, if0.solid_down};
        g_tr[0][c]  = if0.diag_solid;
        a_tr[0][c]  = if0.worldmap_addr;
        vmask[1][c] = if1.sensor_valid;
        bmask[1][c] = if1.busy;
        f_tr[1][c]  = {if1.out_of_map, if1.on_goal, if1.on_hazard, if1.solid_left,
                       if1.solid_right, if1.solid_up, if1.solid_down};
        g_tr[1][c]  = if1.diag_solid;
        a_tr[1][c]  = if1.worldmap_addr;
    endtask

    // Cycle c: start = smask[c], reset low when rmask[c]; loc is scrambled after cycle 0.
    task automatic run(input logic [7:0] x, input logic [7:0] y, input logic [19:0] smask,
                       input logic [19:0] rmask);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_75);
            #1;
            start = smask[c];
            reset = !rmask[c];
            if (c == 0) begin
                loc_x = x;
                loc_y = y;
            end else begin
                loc_x = 8'h33 + 8'(c);
                loc_y = 8'h45;
            end
            @(negedge clk_75);
            sample(c);
        end
    endtask

    task automatic set_map(input vec_t v);
        int cx, cy;
        for (int i = 0; i < 16384; i++) map_mem[i] = 2'b00;
        cx = int'(v.x) % 128;
        cy = int'(v.y) % 128;
        map_mem[cy*128 + cx] = v.c;
        if (!v.oom) begin
            if (cx > 0)   map_mem[cy*128 + cx - 1]   = v.l;
            if (cx < 127) map_mem[cy*128 + cx + 1]   = v.r;
            if (cy > 0)   map_mem[(cy-1)*128 + cx]   = v.u;
            if (cy < 127) map_mem[(cy+1)*128 + cx]   = v.d;
        end
    endtask

    task automatic do_vec(input int i);
        vec_t v;
        int   lat, vc, x, y, dx, dy;
        logic skip, oom;
        logic [13:0] exp_a;
        v   = vecs[i];
        set_map(v);
        run(v.x, v.y, 20'h1, 20'h0);
        x   = int'(v.x);
        y   = int'(v.y);
        oom = (x > 127) || (y > 127);
        for (int d = 0; d < 2; d++) begin
            lat = (d == 0) ? 1 : 3;
            vc  = 6 + lat;
            check($sformatf("v%0d_d%0d_valid", i, d), 32'(vmask[d]), 32'd1 << vc);
            check($sformatf("v%0d_d%0d_busy", i, d), 32'(bmask[d]),
                  ((32'd1 << (5 + lat)) - 1) << 1);
            check($sformatf("v%0d_d%0d_flags", i, d), 32'(f_tr[d][vc]),
                  32'({v.oom, v.goal, v.haz, v.solid}));
            check($sformatf("v%0d_d%0d_hold", i, d), 32'(f_tr[d][19]),
                  32'({v.oom, v.goal, v.haz, v.solid}));
            check($sformatf("v%0d_d%0d_diag", i, d), 32'(g_tr[d][vc]), 32'd0);
            exp_a = last_addr[d];
            for (int k = 0; k < 5; k++) begin
                dx   = (k == 1) ? -1 : (k == 2) ? 1 : 0;
                dy   = (k == 3) ? -1 : (k == 4) ? 1 : 0;
                skip = oom || (k == 1 && x == 0) || (k == 2 && x == 127) ||
                       (k == 3 && y == 0) || (k == 4 && y == 127);
                if (!skip) exp_a = 14'((((y + dy) & 127) * 128) + ((x + dx) & 127));
                check($sformatf("v%0d_d%0d_addr%0d", i, d, k), 32'(a_tr[d][k+1]), 32'(exp_a));
            end
            last_addr[d] = exp_a;
        end
    endtask

    initial begin
        vecs[0] = '{8'd10,  8'd20,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'd10,  8'd20,  2'b11, 2'b00, 2'b01, 2'b00, 2'b01, 4'b0101, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'd0,   8'd0,   2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1010, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'd127, 8'd127, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 4'b1101, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h80,  8'd5,   2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1111, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'd50,  8'h90,  2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1111, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'd64,  8'd64,  2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{8'd127, 8'd0,   2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 4'b1110, 1'b0, 1'b1, 1'b0};
        last_addr[0] = '0;
        last_addr[1] = '0;
        for (int i = 0; i < 16384; i++) map_mem[i] = 2'b00;

        #12;
        check("reset_d0", 32'({if0.busy, if0.sensor_valid, if0.worldmap_addr, if0.solid_left,
              if0.solid_right, if0.solid_up, if0.solid_down, if0.on_hazard, if0.on_goal,
              if0.out_of_map, if0.diag_solid}), 32'd0);
        check("reset_d1", 32'({if1.busy, if1.sensor_valid, if1.worldmap_addr, if1.solid_left,
              if1.solid_right, if1.solid_up, if1.solid_down, if1.on_hazard, if1.on_goal,
              if1.out_of_map, if1.diag_solid}), 32'd0);
        @(posedge clk_75);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 8; i++) do_vec(i);

        // Starts in cycles 2,3 (busy) are dropped; cycle 7 restarts dut0 only.
        set_map(vecs[0]);
        run(8'd10, 8'd20, 20'h0008D, 20'h0);
        check("busy_d0_valid", 32'(vmask[0]), (32'd1 << 7) | (32'd1 << 14));
        check("busy_d1_valid", 32'(vmask[1]), 32'd1 << 9);
        check("busy_d0_busy", 32'(bmask[0]), 32'h3F7E);
        check("busy_d0_flags2", 32'(f_tr[0][14]), 32'd0);
        last_addr[0] = 14'((8'h46 * 128) + 8'h3A);
        last_addr[1] = 14'((21 * 128) + 10);

        // Abort a sweep with reset in cycles 3..4 after flags were set.
        do_vec(1);
        run(8'd10, 8'd20, 20'h1, 20'h00018);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_d%0d_outs", d),
                  32'({bmask[d][3], vmask[d][3], a_tr[d][3], f_tr[d][3], g_tr[d][3]}), 32'd0);
            check($sformatf("rst_d%0d_valid", d), 32'(vmask[d]), 32'd0);
            last_addr[d] = '0;
        end
        do_vec(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
